// File: rtl/cp0_intc.sv
// Coprocessor-0 beside the M stage: SR/Cause/EPC, Count/Compare timer,
// external interrupt latching and exception/interrupt request generation.
module cp0_intc #(
  parameter int unsigned NUM_HWINT    = 6,
  parameter logic [5:0]  EDGE_MASK    = 6'b000000,
  parameter bit          TIMER_EN     = 1'b1,
  parameter int unsigned TIMER_DIV    = 0,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID         = 32'h0000_0001
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [4:0]           reg_addr,
  input  logic [31:0]          data_in,
  input  logic [31:0]          pc_now,
  input  logic                 bd_in,
  input  logic [4:0]           exccode_in,
  input  logic                 slot_valid,
  input  logic                 eret,
  input  logic [NUM_HWINT-1:0] hwint,
  output logic [31:0]          data_out,
  output logic [31:0]          epc_out,
  output logic                 req,
  output logic [31:0]          handler_pc,
  output logic                 exl_out,
  output logic                 timer_irq
);

  localparam logic [6:0]  LINE_MASK7  = 7'((1 << NUM_HWINT) - 1);
  localparam logic [5:0]  LINE_MASK   = LINE_MASK7[5:0];
  localparam logic [5:0]  EDGE_LINES  = EDGE_MASK & LINE_MASK;
  localparam logic [5:0]  LEVEL_LINES = ~EDGE_MASK & LINE_MASK;
  localparam int unsigned DIV_W       = (TIMER_DIV > 0) ? TIMER_DIV : 1;

  logic [7:0]       r_im;
  logic             r_exl;
  logic             r_ie;
  logic             r_bd;
  logic             r_ti;
  logic [4:0]       r_exc;
  logic [5:0]       r_ip;
  logic [5:0]       r_hw_prev;
  logic [31:0]      r_epc;
  logic [31:0]      r_count;
  logic [31:0]      r_compare;
  logic [DIV_W-1:0] r_div;

  logic [5:0]  w_hw6;
  logic [5:0]  w_ip_rd;
  logic [5:0]  w_ip_nxt;
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_wr;
  logic        w_wr_sr;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_tick;
  logic [31:0] w_count_nxt;
  logic        w_ti_nxt;

  // Request generation from registered state; the timer bit shares IP[15] with line 5.
  always_comb begin
    w_hw6                  = '0;
    w_hw6[NUM_HWINT-1:0]   = hwint;
    w_ip_rd                = r_ip | {r_ti, 5'b00000};
    w_int_req    = r_ie & ~r_exl & (|({w_ip_rd, 2'b00} & r_im)) & slot_valid;
    w_exc_req    = ~r_exl & (exccode_in != 5'd0);
    req          = reset & (w_int_req | w_exc_req);
    w_wr         = we & ~req;
    w_wr_sr      = w_wr && (reg_addr == 5'd12);
    w_wr_cause   = w_wr && (reg_addr == 5'd13);
    w_wr_epc     = w_wr && (reg_addr == 5'd14);
    w_wr_count   = w_wr && (reg_addr == 5'd9);
    w_wr_compare = w_wr && (reg_addr == 5'd11);
  end

  // Next IP: level lines follow the pin, edge lines are sticky with set beating a Cause-write clear.
  always_comb begin
    w_ip_nxt = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (LEVEL_LINES[i]) begin
        w_ip_nxt[i] = w_hw6[i];
      end else if (EDGE_LINES[i]) begin
        w_ip_nxt[i] = r_ip[i];
        if (w_hw6[i] & ~r_hw_prev[i]) begin
          w_ip_nxt[i] = 1'b1;
        end else if (w_wr_cause & ~data_in[10+i]) begin
          w_ip_nxt[i] = 1'b0;
        end
      end
    end
  end

  // Timer next-state: an mtc0 Count overrides the increment; TI is checked against the new Count.
  always_comb begin
    w_tick      = TIMER_EN && ((TIMER_DIV == 0) || (r_div == '1));
    w_count_nxt = r_count;
    if (w_tick) begin
      w_count_nxt = r_count + 32'd1;
    end
    if (w_wr_count) begin
      w_count_nxt = data_in;
    end
    w_ti_nxt = r_ti;
    if (w_wr_compare) begin
      w_ti_nxt = 1'b0;
    end else if (w_tick && (w_count_nxt == r_compare)) begin
      w_ti_nxt = 1'b1;
    end
    if (!TIMER_EN) begin
      w_count_nxt = '0;
      w_ti_nxt    = 1'b0;
    end
  end

  // Interrupt line sampling and edge history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ip      <= '0;
      r_hw_prev <= '0;
    end else begin
      r_ip      <= w_ip_nxt;
      r_hw_prev <= w_hw6 & LINE_MASK;
    end
  end

  // Count/Compare timer and prescaler.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
      r_div     <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_ti    <= w_ti_nxt;
      r_div   <= r_div + 1'b1;
      if (w_wr_compare && TIMER_EN) begin
        r_compare <= data_in;
      end
    end
  end

  // SR/Cause/EPC: exception entry takes precedence over eret and mtc0 in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im  <= '0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_bd  <= 1'b0;
      r_exc <= '0;
      r_epc <= '0;
    end else if (req) begin
      r_exl <= 1'b1;
      r_bd  <= bd_in;
      r_exc <= w_int_req ? 5'd0 : exccode_in;
      r_epc <= bd_in ? (pc_now - 32'd4) : pc_now;
    end else begin
      if (eret) begin
        r_exl <= 1'b0;
      end else if (w_wr_sr) begin
        r_exl <= data_in[1];
      end
      if (w_wr_sr) begin
        r_im <= data_in[15:8];
        r_ie <= data_in[0];
      end
      if (w_wr_epc) begin
        r_epc <= data_in;
      end
    end
  end

  // mfc0 read mux.
  always_comb begin
    data_out = '0;
    case (reg_addr)
      5'd9:    data_out = r_count;
      5'd11:   data_out = r_compare;
      5'd12:   data_out = {16'h0000, r_im, 6'b000000, r_exl, r_ie};
      5'd13:   data_out = {r_bd, r_ti, 14'h0000, w_ip_rd, 3'b000, r_exc, 2'b00};
      5'd14:   data_out = r_epc;
      5'd15:   data_out = PRID;
      default: data_out = '0;
    endcase
  end

  assign epc_out    = r_epc;
  assign handler_pc = HANDLER_ADDR;
  assign exl_out    = r_exl;
  assign timer_irq  = r_ti;

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: expectations are queued as stimulus is applied
// and popped when the corresponding output is sampled.
module tb_cp0_intc;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  reg_addr;
  logic [31:0] data_in;
  logic [31:0] pc_now;
  logic        bd_in;
  logic [4:0]  exccode_in;
  logic        slot_valid;
  logic        eret;
  logic [5:0]  hwint;
  logic [31:0] data_out;
  logic [31:0] epc_out;
  logic        req;
  logic [31:0] handler_pc;
  logic        exl_out;
  logic        timer_irq;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  cp0_intc #(
    .NUM_HWINT   (6),
    .EDGE_MASK   (6'b000010),
    .TIMER_EN    (1'b1),
    .TIMER_DIV   (0),
    .HANDLER_ADDR(32'h0000_4180),
    .PRID        (32'h0000_0001)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .reg_addr  (reg_addr),
    .data_in   (data_in),
    .pc_now    (pc_now),
    .bd_in     (bd_in),
    .exccode_in(exccode_in),
    .slot_valid(slot_valid),
    .eret      (eret),
    .hwint     (hwint),
    .data_out  (data_out),
    .epc_out   (epc_out),
    .req       (req),
    .handler_pc(handler_pc),
    .exl_out   (exl_out),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic cmp(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %h expected <entry>", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] val);
    push(tag, val);
    cmp(obs);
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] val);
    reg_addr = addr;
    push(tag, val);
    #1;
    cmp(data_out);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] val);
    we       = 1'b1;
    reg_addr = addr;
    data_in  = val;
    step();
    we       = 1'b0;
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; reg_addr = '0; data_in = '0; pc_now = '0; bd_in = 1'b0;
    exccode_in = '0; slot_valid = 1'b0; eret = 1'b0; hwint = '0;
    repeat (2) step();
    reset = 1'b1;

    // 1: reset mid-run with EXL=1, Count=5
    mtc0(5'd12, 32'h0000_0002);
    repeat (4) step();
    settle();
    chk("exl_pre_reset", exl_out, 1);
    rd("count_pre_reset", 5'd9, 32'd5);
    step();
    reset = 1'b0; exccode_in = 5'd4; slot_valid = 1'b1;
    push("req_in_reset", 0);
    #1;
    cmp(req);
    rd("sr_in_reset", 5'd12, 32'h0);
    rd("count_in_reset", 5'd9, 32'h0);
    chk("exl_in_reset", exl_out, 0);
    exccode_in = '0; slot_valid = 1'b0;
    step(); step();
    reset = 1'b1;

    // 2: level interrupt on line 0
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'b000001; slot_valid = 1'b1; pc_now = 32'h3010;
    settle();
    chk("req_before_ip", req, 0);
    step();
    settle();
    chk("req_int", req, 1);
    step();
    hwint = '0; slot_valid = 1'b0;
    settle();
    chk("req_exl_block", req, 0);
    chk("exl_int", exl_out, 1);
    chk("epc_int", epc_out, 32'h3010);
    rd("cause_int", 5'd13, 32'h0000_0400);
    eret = 1'b1;
    step();
    eret = 1'b0;
    settle();
    chk("exl_eret1", exl_out, 0);
    chk("req_after_eret1", req, 0);

    // 3: exception in a delay slot with IE=0
    mtc0(5'd12, 32'h0);
    exccode_in = 5'd12; bd_in = 1'b1; pc_now = 32'h3024; slot_valid = 1'b1;
    settle();
    chk("req_exc", req, 1);
    step();
    exccode_in = '0; bd_in = 1'b0; slot_valid = 1'b0;
    settle();
    chk("epc_bd", epc_out, 32'h3020);
    rd("cause_exc", 5'd13, 32'h8000_0030);
    chk("exl_exc", exl_out, 1);
    eret = 1'b1;
    step();
    eret = 1'b0;

    // 4: edge-sensitive line 1
    hwint = 6'b000010;
    step();
    hwint = '0;
    step(); step();
    settle();
    rd("ip11_sticky", 5'd13, 32'h8000_0830);
    mtc0(5'd13, 32'h0000_0800);
    settle();
    rd("ip11_write1_keeps", 5'd13, 32'h8000_0830);
    mtc0(5'd13, 32'h0);
    settle();
    rd("ip11_cleared", 5'd13, 32'h8000_0030);
    hwint = 6'b000010; we = 1'b1; reg_addr = 5'd13; data_in = 32'h0;
    step();
    we = 1'b0; hwint = '0;
    settle();
    rd("ip11_set_wins", 5'd13, 32'h8000_0830);
    mtc0(5'd13, 32'h0);
    settle();
    rd("ip11_cleared2", 5'd13, 32'h8000_0030);

    // 5: Count/Compare timer
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    repeat (9) step();
    settle();
    chk("ti_before", timer_irq, 0);
    rd("count_9", 5'd9, 32'd9);
    step();
    settle();
    chk("ti_set", timer_irq, 1);
    rd("count_10", 5'd9, 32'd10);
    rd("cause_ti", 5'd13, 32'hC000_8030);
    mtc0(5'd12, 32'h0000_8001);
    slot_valid = 1'b1; pc_now = 32'h5000;
    settle();
    chk("req_timer", req, 1);
    step();
    slot_valid = 1'b0;
    settle();
    chk("exl_timer", exl_out, 1);
    rd("cause_timer", 5'd13, 32'h4000_8000);
    chk("epc_timer", epc_out, 32'h5000);
    mtc0(5'd11, 32'd100);
    settle();
    chk("ti_cleared", timer_irq, 0);
    eret = 1'b1;
    step();
    eret = 1'b0;
    settle();
    chk("exl_eret_timer", exl_out, 0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    settle();
    rd("count_max", 5'd9, 32'hFFFF_FFFF);
    step();
    settle();
    rd("count_wrap", 5'd9, 32'h0);

    // 6: interrupt beats exception, same-cycle mtc0 SR dropped, then eret
    hwint = 6'b000001;
    mtc0(5'd12, 32'h0000_0401);
    slot_valid = 1'b1; exccode_in = 5'd4; pc_now = 32'h6000;
    we = 1'b1; reg_addr = 5'd12; data_in = 32'h0;
    settle();
    chk("req_both", req, 1);
    step();
    we = 1'b0; exccode_in = '0; slot_valid = 1'b0; hwint = '0;
    settle();
    rd("sr_write_dropped", 5'd12, 32'h0000_0403);
    rd("cause_int_prio", 5'd13, 32'h0000_0400);
    chk("epc_prio", epc_out, 32'h6000);
    eret = 1'b1;
    step();
    eret = 1'b0;
    settle();
    chk("exl_eret6", exl_out, 0);
    rd("sr_after_eret", 5'd12, 32'h0000_0401);
    rd("prid", 5'd15, 32'h0000_0001);
    settle();
    rd("unused_reg", 5'd3, 32'h0);
    chk("handler_pc", handler_pc, 32'h0000_4180);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
